// File: rtl/inst_defs.sv
// Shared instruction-pipeline definitions: hazard codes driven by the hazard
// unit and the stage codes used to specialise per-stage behaviour.
package inst_defs;

  localparam int HAZARD_W = 4;

  localparam logic [HAZARD_W-1:0] NONE        = 4'd0;
  localparam logic [HAZARD_W-1:0] FLUSH_ALL   = 4'd1;
  localparam logic [HAZARD_W-1:0] FLUSH_EARLY = 4'd2;
  localparam logic [HAZARD_W-1:0] STALL_EARLY = 4'd3;
  localparam logic [HAZARD_W-1:0] STALL_MMU   = 4'd4;

  typedef enum logic [1:0] {
    STAGE_ID  = 2'd0,
    STAGE_EX  = 2'd1,
    STAGE_MEM = 2'd2,
    STAGE_WB  = 2'd3
  } stage_e;

endpackage

// File: rtl/pipe_stage_pkg.sv
// Local helpers for pipe_stage: hazard-to-action decode and pointer wrap.
package pipe_stage_pkg;
  import inst_defs::*;

  localparam int CTR_W = 16;

  typedef enum logic [1:0] {
    ACT_NORMAL = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_FREEZE = 2'd2,
    ACT_FLUSH  = 2'd3
  } action_e;

  // Resolve the hazard code for a given stage; checks are ordered so that
  // flush beats freeze beats bubble. Unknown codes fall through to normal.
  function automatic action_e decode_action(logic [HAZARD_W-1:0] hazard, stage_e stage);
    if ((hazard == FLUSH_ALL && stage != STAGE_WB) ||
        (hazard == FLUSH_EARLY && stage == STAGE_ID))
      return ACT_FLUSH;
    if (hazard == STALL_MMU)
      return ACT_FREEZE;
    if (hazard == STALL_EARLY && stage == STAGE_EX)
      return ACT_BUBBLE;
    return ACT_NORMAL;
  endfunction

  // Circular-buffer pointer advance: DEPTH-1 wraps back to 0.
  function automatic int unsigned wrap_inc(int unsigned ptr, int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/pipe_stage_ctr.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module pipe_stage_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count one per cycle with inc high, holding at the ceiling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc && count != {W{1'b1}})
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_stage.sv
// Pipeline stage buffer: small circular FIFO with valid/ready on both sides,
// reacting to hazard-unit codes (flush, freeze, bubble) per stage identity.
module pipe_stage
  import inst_defs::*, pipe_stage_pkg::*;
#(
  parameter stage_e             STAGE       = STAGE_ID,
  parameter int                 WIDTH       = 32,
  parameter int                 DEPTH       = 2,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 hazard_signal,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [15:0]                flush_cnt,
  output logic [15:0]                stall_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  action_e act;
  logic    flush, freeze, bubble;
  logic    push, pop;
  logic    flush_inc, stall_inc;

  // Hazard decode and handshake qualification.
  always_comb begin
    act      = decode_action(hazard_signal, STAGE);
    flush    = (act == ACT_FLUSH);
    freeze   = (act == ACT_FREEZE);
    bubble   = (act == ACT_BUBBLE);
    out_valid = (count != '0) && !flush && !freeze && !bubble;
    pop      = out_valid && out_ready;
    // A full stage still accepts when the head leaves on the same edge.
    in_ready = !flush && !freeze && ((count < CNT_W'(DEPTH)) || pop);
    push     = in_valid && in_ready;
    out_data = out_valid ? mem[rd_ptr] : RESET_VALUE;
    flush_inc = flush;
    stall_inc = !flush && (freeze || bubble || ((count != '0) && !out_ready));
  end

  assign occupancy = count;

  // Pointer and count bookkeeping; flush empties, freeze holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (!freeze) begin
      if (push)
        wr_ptr <= PTR_W'(wrap_inc(32'(wr_ptr), DEPTH));
      if (pop)
        rd_ptr <= PTR_W'(wrap_inc(32'(rd_ptr), DEPTH));
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Payload storage; contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  pipe_stage_ctr #(.W(CTR_W)) u_flush_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  pipe_stage_ctr #(.W(CTR_W)) u_stall_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: ID, EX and WB instances share stimulus; each scenario
// task drives inputs and compares outputs against a data scoreboard.
module tb_pipe_stage;
  import inst_defs::*;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int OW = $clog2(D+1);

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   hazard;
  logic         in_valid, out_ready;
  logic [W-1:0] in_data;

  logic          i_in_ready, i_out_valid, x_in_ready, x_out_valid, w_in_ready, w_out_valid;
  logic [W-1:0]  i_out_data, x_out_data, w_out_data;
  logic [OW-1:0] i_occ, x_occ, w_occ;
  logic [15:0]   i_fcnt, i_scnt, x_fcnt, x_scnt, w_fcnt, w_scnt;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] sb [$];
  logic [W-1:0] exp_d;

  always #5 clk = ~clk;

  pipe_stage #(.STAGE(STAGE_ID), .WIDTH(W), .DEPTH(D)) dut_id (
    .clk(clk), .rst_n(rst_n), .hazard_signal(hazard), .in_valid(in_valid),
    .in_ready(i_in_ready), .in_data(in_data), .out_valid(i_out_valid),
    .out_ready(out_ready), .out_data(i_out_data), .occupancy(i_occ),
    .flush_cnt(i_fcnt), .stall_cnt(i_scnt));

  pipe_stage #(.STAGE(STAGE_EX), .WIDTH(W), .DEPTH(D)) dut_ex (
    .clk(clk), .rst_n(rst_n), .hazard_signal(hazard), .in_valid(in_valid),
    .in_ready(x_in_ready), .in_data(in_data), .out_valid(x_out_valid),
    .out_ready(out_ready), .out_data(x_out_data), .occupancy(x_occ),
    .flush_cnt(x_fcnt), .stall_cnt(x_scnt));

  pipe_stage #(.STAGE(STAGE_WB), .WIDTH(W), .DEPTH(D)) dut_wb (
    .clk(clk), .rst_n(rst_n), .hazard_signal(hazard), .in_valid(in_valid),
    .in_ready(w_in_ready), .in_data(in_data), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_data(w_out_data), .occupancy(w_occ),
    .flush_cnt(w_fcnt), .stall_cnt(w_scnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; hazard = NONE; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    sb.delete();
    tick();
    rst_n = 1'b1;
  endtask

  // Push two words with the downstream blocked; records them in the scoreboard.
  task automatic fill_two(input logic [W-1:0] a, input logic [W-1:0] b);
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = a; sb.push_back(a); tick();
    in_data = b; sb.push_back(b); tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hazard = NONE; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    #1;
    tick(); tick();
    checks++; if (i_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", i_out_valid); end
    checks++; if (i_out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", i_out_data); end
    checks++; if (i_occ !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", i_occ); end
    checks++; if (i_fcnt !== 16'd0 || i_scnt !== 16'd0) begin failures++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", i_fcnt, i_scnt); end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_fill_drain();
    apply_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0A;
    #1;
    checks++; if (i_in_ready !== 1'b1 || i_out_valid !== 1'b0) begin failures++; $display("FAIL empty_hs got=%b/%b exp=1/0", i_in_ready, i_out_valid); end
    sb.push_back(8'h0A); tick();
    in_data = 8'h0B;
    #1;
    checks++; if (i_out_valid !== 1'b1 || i_out_data !== sb[0]) begin failures++; $display("FAIL zero_latency got=%b/%h exp=1/%h", i_out_valid, i_out_data, sb[0]); end
    sb.push_back(8'h0B); tick();
    in_valid = 1'b0;
    #1;
    checks++; if (i_occ !== 2'd2 || i_in_ready !== 1'b0) begin failures++; $display("FAIL full_state got=%0d/%b exp=2/0", i_occ, i_in_ready); end
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      exp_d = sb.pop_front();
      checks++; if (i_out_valid !== 1'b1 || i_out_data !== exp_d) begin failures++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", k, i_out_valid, i_out_data, exp_d); end
      tick();
    end
    #1;
    checks++; if (i_out_valid !== 1'b0 || i_out_data !== 8'h00 || i_occ !== 2'd0) begin failures++; $display("FAIL drained got=%b/%h/%0d exp=0/00/0", i_out_valid, i_out_data, i_occ); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    fill_two(8'h0A, 8'h0B);
    in_valid = 1'b1; in_data = 8'h0C; out_ready = 1'b1;
    #1;
    exp_d = sb.pop_front();
    checks++; if (i_in_ready !== 1'b1 || i_out_data !== exp_d) begin failures++; $display("FAIL full_accept got=%b/%h exp=1/%h", i_in_ready, i_out_data, exp_d); end
    sb.push_back(8'h0C); tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (i_occ !== 2'd2 || i_out_data !== sb[0]) begin failures++; $display("FAIL full_after got=%0d/%h exp=2/%h", i_occ, i_out_data, sb[0]); end
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      exp_d = sb.pop_front();
      checks++; if (i_out_data !== exp_d) begin failures++; $display("FAIL bb_drain_%0d got=%h exp=%h", k, i_out_data, exp_d); end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    apply_reset();
    fill_two(8'h0A, 8'h0B);
    hazard = FLUSH_EARLY; in_valid = 1'b1; in_data = 8'h0D; out_ready = 1'b1;
    #1;
    checks++; if (i_out_valid !== 1'b0 || i_in_ready !== 1'b0) begin failures++; $display("FAIL flush_hs got=%b/%b exp=0/0", i_out_valid, i_in_ready); end
    tick();
    hazard = NONE; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (i_occ !== 2'd0 || i_out_valid !== 1'b0) begin failures++; $display("FAIL flush_occ got=%0d/%b exp=0/0", i_occ, i_out_valid); end
    checks++; if (i_fcnt !== 16'd1) begin failures++; $display("FAIL flush_cnt got=%0d exp=1", i_fcnt); end
    checks++; if (i_scnt !== 16'd1) begin failures++; $display("FAIL flush_no_stall got=%0d exp=1", i_scnt); end
    checks++; if (x_fcnt !== 16'd0) begin failures++; $display("FAIL ex_no_flush got=%0d exp=0", x_fcnt); end
    sb.delete();
  endtask

  task automatic test_freeze();
    apply_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0A; sb.push_back(8'h0A); tick();
    hazard = STALL_MMU; in_data = 8'h55; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (i_out_valid !== 1'b0 || i_in_ready !== 1'b0) begin failures++; $display("FAIL freeze_hs_%0d got=%b/%b exp=0/0", k, i_out_valid, i_in_ready); end
      tick();
    end
    hazard = NONE; in_valid = 1'b0;
    #1;
    checks++; if (i_scnt !== 16'd3) begin failures++; $display("FAIL freeze_stall_cnt got=%0d exp=3", i_scnt); end
    checks++; if (i_occ !== 2'd1) begin failures++; $display("FAIL freeze_occ got=%0d exp=1", i_occ); end
    exp_d = sb.pop_front();
    checks++; if (i_out_data !== exp_d) begin failures++; $display("FAIL freeze_head got=%h exp=%h", i_out_data, exp_d); end
    tick();
    #1;
    checks++; if (i_occ !== 2'd0) begin failures++; $display("FAIL freeze_pop got=%0d exp=0", i_occ); end
    out_ready = 1'b0;
  endtask

  task automatic test_bubble();
    apply_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0E; sb.push_back(8'h0E); tick();
    hazard = STALL_EARLY; in_data = 8'h0F; out_ready = 1'b1;
    #1;
    checks++; if (x_out_valid !== 1'b0 || x_in_ready !== 1'b1) begin failures++; $display("FAIL bubble_hs got=%b/%b exp=0/1", x_out_valid, x_in_ready); end
    sb.push_back(8'h0F); tick();
    hazard = NONE; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (x_occ !== 2'd2) begin failures++; $display("FAIL bubble_occ got=%0d exp=2", x_occ); end
    checks++; if (x_scnt !== 16'd1) begin failures++; $display("FAIL bubble_stall got=%0d exp=1", x_scnt); end
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      exp_d = sb.pop_front();
      checks++; if (x_out_valid !== 1'b1 || x_out_data !== exp_d) begin failures++; $display("FAIL bubble_drain_%0d got=%b/%h exp=1/%h", k, x_out_valid, x_out_data, exp_d); end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wb_no_flush();
    apply_reset();
    fill_two(8'h21, 8'h22);
    hazard = FLUSH_ALL;
    #1;
    checks++; if (w_out_valid !== 1'b1 || w_out_data !== sb[0]) begin failures++; $display("FAIL wb_flushall_head got=%b/%h exp=1/%h", w_out_valid, w_out_data, sb[0]); end
    tick();
    hazard = NONE;
    #1;
    checks++; if (w_occ !== 2'd2 || w_fcnt !== 16'd0) begin failures++; $display("FAIL wb_no_flush got=%0d/%0d exp=2/0", w_occ, w_fcnt); end
    checks++; if (i_occ !== 2'd0 || i_fcnt !== 16'd1) begin failures++; $display("FAIL id_flushall got=%0d/%0d exp=0/1", i_occ, i_fcnt); end
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      exp_d = sb.pop_front();
      checks++; if (w_out_data !== exp_d) begin failures++; $display("FAIL wb_drain_%0d got=%h exp=%h", k, w_out_data, exp_d); end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    fill_two(8'h31, 8'h32);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (i_out_valid !== 1'b0 || i_out_data !== 8'h00) begin failures++; $display("FAIL async_out got=%b/%h exp=0/00", i_out_valid, i_out_data); end
    checks++; if (i_occ !== 2'd0 || i_scnt !== 16'd0 || i_fcnt !== 16'd0) begin failures++; $display("FAIL async_cnts got=%0d/%0d/%0d exp=0/0/0", i_occ, i_scnt, i_fcnt); end
    sb.delete();
    in_valid = 1'b1; in_data = 8'h3C;
    #1;
    rst_n = 1'b1;
    sb.push_back(8'h3C); tick();
    in_valid = 1'b0;
    #1;
    exp_d = sb.pop_front();
    checks++; if (i_occ !== 2'd1 || i_out_data !== exp_d) begin failures++; $display("FAIL resume got=%0d/%h exp=1/%h", i_occ, i_out_data, exp_d); end
  endtask

  initial begin
    rst_n = 1'b0; hazard = NONE; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_flush();
    test_freeze();
    test_bubble();
    test_wb_no_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter STAGE, default STAGE_ID, pipeline stage code that selects which hazard actions apply.
REQ-002 SHALL have parameter WIDTH, default 32, payload width in bits.
REQ-003 SHALL have parameter DEPTH, default 2, number of buffer entries (>=1).
REQ-004 SHALL have parameter RESET_VALUE, default 0, payload driven when no valid data is presented.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port hazard_signal  input  4  hazard code from the hazard unit.
REQ-008 SHALL have port in_valid  input  1  upstream data valid.
REQ-009 SHALL have port in_ready  output  1  stage can accept data.
REQ-010 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-011 SHALL have port out_valid  output  1  head entry valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts.
REQ-013 SHALL have port out_data  output  WIDTH  head payload.
REQ-014 SHALL have port occupancy  output  clog2(DEPTH+1)  number of entries held.
REQ-015 SHALL have port flush_cnt  output  16  saturating count of flush cycles.
REQ-016 SHALL have port stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-017 SHALL hold entries in a circular buffer with read pointer, write pointer and count; pointers wrap from DEPTH-1 to 0.
REQ-018 SHALL define flush = (hazard_signal==FLUSH_ALL and STAGE!=STAGE_WB) or (hazard_signal==FLUSH_EARLY and STAGE==STAGE_ID).
REQ-019 SHALL define freeze = hazard_signal==STALL_MMU.
REQ-020 SHALL define bubble = hazard_signal==STALL_EARLY and STAGE==STAGE_EX.
REQ-021 SHALL treat every other hazard code, including undefined codes, as normal operation.
REQ-022 SHALL apply the priority reset > flush > freeze > bubble > normal.
REQ-023 SHALL drive in_ready = not flush and not freeze and (count<DEPTH or (out_valid and out_ready)), so a full stage accepts on the same cycle it pops.
REQ-024 SHALL drive out_valid = count!=0 and not flush and not freeze and not bubble.
REQ-025 SHALL drive out_data = head entry when out_valid, else RESET_VALUE.
REQ-026 SHALL push in_data at the write pointer on a rising edge when in_valid and in_ready.
REQ-027 SHALL pop the head on a rising edge when out_valid and out_ready.
REQ-028 SHALL update count by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-029 SHALL, on a flush cycle, set count and both pointers to 0 at the next edge and discard any in_valid presented that cycle.
REQ-030 SHALL, on a freeze cycle, hold all state unchanged.
REQ-031 SHALL, on a bubble cycle, pop nothing while still allowing a push if space exists.
REQ-032 SHALL increment flush_cnt each flush cycle, saturating at 0xFFFF.
REQ-033 SHALL increment stall_cnt each cycle with freeze, bubble, or (count!=0 and not out_ready), saturating at 0xFFFF, and SHALL NOT increment it on a flush cycle.
REQ-034 SHALL have zero latency from entry to head when the stage is empty: data pushed at edge N is presented at out_data after edge N.

Reset
REQ-035 SHALL, while rst_n=0, asynchronously clear count, pointers, flush_cnt and stall_cnt, giving out_valid=0, out_data=RESET_VALUE and occupancy=0.
REQ-036 SHALL drop any entry held when reset is asserted mid-operation, and SHALL resume accepting data on the first edge after rst_n rises.
REQ-037 SHALL NOT require the storage array to be reset.

Structure
REQ-038 SHALL take hazard codes (FLUSH_ALL, FLUSH_EARLY, STALL_EARLY, STALL_MMU, NONE) and stage codes (STAGE_ID, STAGE_EX, STAGE_MEM, STAGE_WB) from the shared inst_defs definitions and SHALL NOT define them locally.
REQ-039 SHALL implement each 16-bit saturating counter as an instance of the sub-module pipe_stage_ctr (inc input, saturating output, async active-low reset), instantiated twice.

Verification
REQ-040 SHALL test fill and drain with DEPTH=2, out_ready=0: push 0xA, 0xB -> occupancy=2 and in_ready=0; then out_ready=1 -> out_data 0xA, then 0xB, then out_valid=0 with out_data=0.
REQ-041 SHALL test a full stage with push 0xC and out_ready=1 in the same cycle -> pop 0xA, occupancy stays 2, head becomes 0xB.
REQ-042 SHALL test STAGE=STAGE_ID holding 2 entries with hazard FLUSH_EARLY for 1 cycle and in_valid=1 (0xD) -> occupancy=0, 0xD discarded, flush_cnt=1.
REQ-043 SHALL test STALL_MMU for 3 cycles with in_valid=1 and out_ready=1 -> no push or pop, state unchanged, stall_cnt=3.
REQ-044 SHALL test STAGE=STAGE_EX with STALL_EARLY for 1 cycle, 1 entry 0xE held, in_valid=1 (0xF) -> out_valid=0 that cycle, occupancy=2 afterwards, 0xE emitted first.
REQ-045 SHALL test rst_n dropped asynchronously between edges with 2 entries held -> out_valid=0 immediately, all counters 0; STAGE=STAGE_WB with FLUSH_ALL -> no flush.
